addr8s_redundant_sched: RTL and testbench
=========================================

Name: addr8s_redundant_sched

Overview:
- Round-robin scheduler that shares one combinational 8-bit signed adder (addr8s family, O[8:0] = A + B sign-extended) between N_REQ requesters.
- Uses time redundancy for fault resilience: every addition runs twice on the shared adder, once as A+B and once with operands swapped (B+A), and the two results are compared.
- On mismatch the pair is retried up to MAX_RETRY times; if it still mismatches, the response carries an error flag.
- Sits between client request ports and a single external adder instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- MAX_RETRY, 2, extra run-pairs allowed after the first mismatching pair (0..7)
- ID_W, 2, width of requester index; must equal clog2(N_REQ)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; at most one bit high
- req_a  in  8*N_REQ  signed operand A; requester i uses bits [8i+7:8i]
- req_b  in  8*N_REQ  signed operand B; same packing as req_a
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the requester being answered
- rsp_sum  out  9  signed sum from the first run of the final pair
- rsp_err  out  1  1 = comparison still failed after all retries
- add_a  out  8  shared adder operand A
- add_b  out  8  shared adder operand B
- add_o  in  9  shared adder result (combinational, single-cycle path)
- busy  out  1  high whenever state != IDLE
- err_cnt  out  8  saturating count of responses issued with rsp_err=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: state=IDLE, rr_ptr=0, retry_cnt=0, err_cnt=0. All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, add_a, add_b, busy.
- Reset mid-operation: the in-flight transaction is dropped and no response is produced. The requester sees its earlier acceptance only.
- States: IDLE, RUN1, RUN2, CHECK, RESP.
- IDLE, grant:
  - Grant g is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo N_REQ.
  - req_ready[g] is high combinationally in IDLE only. A transfer happens when req_valid[g] and req_ready[g] are both high.
  - On transfer, latch a_r=req_a[g], b_r=req_b[g], id_r=g; set retry_cnt=0, rr_ptr=(g+1) mod N_REQ; go to RUN1.
  - With no valid requests, stay in IDLE.
- RUN1: drive add_a=a_r, add_b=b_r. At the clock edge, capture r1=add_o. Go to RUN2.
- RUN2: drive add_a=b_r, add_b=a_r. At the clock edge, capture r2=add_o. Go to CHECK.
- CHECK (add_a/add_b = 0):
  - r1==r2: go to RESP with sum=r1, err=0.
  - r1!=r2 and retry_cnt<MAX_RETRY: retry_cnt++, go to RUN1.
  - Otherwise: go to RESP with sum=r1, err=1, and err_cnt++ saturating at 255.
- RESP:
  - rsp_valid=1; rsp_id, rsp_sum and rsp_err stay stable while rsp_ready=0.
  - When rsp_ready=1, go to IDLE. rsp_valid drops in the following cycle.
- add_a/add_b are 0 in IDLE, CHECK and RESP, so the shared adder does not toggle when idle.
- Latency: transfer at cycle T → RUN1 at T+1, RUN2 at T+2, CHECK at T+3, rsp_valid at T+4 when clean. Each retry adds 3 cycles.
- Throughput: at most one transaction in flight. Back-to-back minimum is 5 cycles per transaction, with rsp_ready tied high.
- Arithmetic: the block never adds. The sum is whatever add_o returns, interpreted as 9-bit signed; no width extension or truncation is applied.
- Simultaneous events: the request/grant decision in IDLE uses the current rr_ptr. A request that arrives while the block is busy waits; requesters must hold valid and data until accepted.
- A requester deasserting valid before acceptance is not an error and is simply not granted.

Test Plan:
- Single request, requester 1: a=0x7F, b=0x01, ideal adder → req_ready[1] high 1 cycle; rsp_valid at T+4, rsp_id=1, rsp_sum=0x080, rsp_err=0.
- Requester 0: a=0x80, b=0xFF → rsp_sum=0x17F (−129), rsp_err=0, err_cnt=0.
- All four requesting continuously, rsp_ready=1 → grant order 0,1,2,3,0; each response 5 cycles apart; rr_ptr wraps from 3 to 0.
- Adder model flips add_o[0] on RUN1 of the first pair only, a=0x10, b=0x20 → one retry; rsp_valid at T+7, rsp_sum=0x030, rsp_err=0.
- Persistent fault (add_o[3] stuck-at-1 during RUN2 only), a=0x00, b=0x00, MAX_RETRY=2 → 3 pairs run; rsp_valid at T+10, rsp_sum=0x000, rsp_err=1, err_cnt=1.
- Backpressure: hold rsp_ready=0 for 6 cycles in RESP → outputs stable, busy=1. Then assert rst_n=0 during RUN2 of the next transaction → next cycle state=IDLE, all outputs 0, no response for that request.

Source files
------------

// File: rtl/addr8s_redundant_sched.sv
// Round-robin scheduler sharing one external 8-bit signed adder between N_REQ requesters.
// Each sum is computed twice (A+B, then B+A) and compared; mismatching pairs are retried.
module addr8s_redundant_sched #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned ID_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [8:0]           rsp_sum,
  output logic                 rsp_err,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  input  logic [8:0]           add_o,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  typedef enum logic [2:0] {IDLE, RUN1, RUN2, CHECK, RESP} state_t;

  state_t          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] id_q;
  logic [7:0]      a_q;
  logic [7:0]      b_q;
  logic [8:0]      r1_q;
  logic [8:0]      r2_q;
  logic [2:0]      retry_q;
  logic [7:0]      err_cnt_q;
  logic [7:0]      add_a_q;
  logic [7:0]      add_b_q;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [8:0]      rsp_sum_q;
  logic            rsp_err_q;

  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic [ID_W:0]   scan;
  logic [ID_W-1:0] nxt_ptr;
  logic [7:0]      g_a;
  logic [7:0]      g_b;

  // Search upward from rr_ptr, wrapping modulo N_REQ (N_REQ need not be a power of two).
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(N_REQ)) begin
        scan = scan - (ID_W+1)'(N_REQ);
      end
      if (!grant_vld && req_valid[scan[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = scan[ID_W-1:0];
      end
    end
  end

  always_comb begin
    g_a = '0;
    g_b = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == grant_id) begin
        g_a = req_a[8*k +: 8];
        g_b = req_b[8*k +: 8];
      end
    end
  end

  always_comb begin
    nxt_ptr = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + ID_W'(1);
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && grant_vld) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      retry_q     <= '0;
      err_cnt_q   <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            a_q      <= g_a;
            b_q      <= g_b;
            id_q     <= grant_id;
            retry_q  <= '0;
            rr_ptr_q <= nxt_ptr;
            add_a_q  <= g_a;
            add_b_q  <= g_b;
            state_q  <= RUN1;
          end
        end
        RUN1: begin
          r1_q    <= add_o;
          add_a_q <= b_q;
          add_b_q <= a_q;
          state_q <= RUN2;
        end
        RUN2: begin
          r2_q    <= add_o;
          add_a_q <= '0;
          add_b_q <= '0;
          state_q <= CHECK;
        end
        CHECK: begin
          if (r1_q == r2_q) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_sum_q   <= r1_q;
            rsp_err_q   <= 1'b0;
            state_q     <= RESP;
          end else if (retry_q < 3'(MAX_RETRY)) begin
            retry_q <= retry_q + 3'd1;
            add_a_q <= a_q;
            add_b_q <= b_q;
            state_q <= RUN1;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_sum_q   <= r1_q;
            rsp_err_q   <= 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_err   = rsp_err_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_addr8s_redundant_sched.sv
// Bench for addr8s_redundant_sched: table vectors, fault-injected adder sequences,
// and randomized traffic against a cycle-level transaction model.
module tb_addr8s_redundant_sched;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [8*NR-1:0] req_a;
  logic [8*NR-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [8:0]      rsp_sum;
  logic            rsp_err;
  logic [7:0]      add_a;
  logic [7:0]      add_b;
  logic [8:0]      add_o;
  logic            busy;
  logic [7:0]      err_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int fault_mode = 0;
  int phase = 0;

  addr8s_redundant_sched #(.N_REQ(NR), .MAX_RETRY(2), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Cycles since the last accepted request: 1 = first RUN1, 2 = first RUN2, +3 per retry.
  always @(posedge clk) begin
    if (!rst_n) phase <= 0;
    else if (|(req_valid & req_ready)) phase <= 1;
    else if (phase != 0 && phase < 100) phase <= phase + 1;
  end

  logic [8:0] ideal;
  assign ideal = {add_a[7], add_a} + {add_b[7], add_b};
  assign add_o = (ideal ^ ((fault_mode == 1 && phase == 1) ? 9'h001 : 9'h000))
               | ((fault_mode == 2 && (phase == 2 || phase == 5 || phase == 8)) ? 9'h008 : 9'h000);

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] s;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] sum_of(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return s[8:0];
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_add_a"}, add_a, 0);
    chk({tag, "_add_b"}, add_b, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_sum"}, rsp_sum, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_txn(input int id, input logic [7:0] a, input logic [7:0] b, input int mode,
                        input int exp_lat, input logic [8:0] exp_sum, input logic exp_err);
    int lat;
    logic [NR-1:0] onehot;
    @(negedge clk);
    fault_mode = mode;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    rsp_ready = 1'b1;
    onehot = '0;
    onehot[id] = 1'b1;
    #1 chk("grant", req_ready, onehot);
    @(negedge clk);
    #1 chk("ready_one_cycle", req_ready, 0);
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      #1 lat++;
    end
    chk("latency", lat, exp_lat);
    chk("rsp_id", rsp_id, id);
    chk("rsp_sum", rsp_sum, exp_sum);
    chk("rsp_err", rsp_err, exp_err);
    @(negedge clk);
    #1 chk("rsp_valid_drop", rsp_valid, 0);
    fault_mode = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, last, g, idx;
    int m_idle, m_wait, m_id, m_ptr;
    logic [8:0] m_sum;
    logic [NR-1:0] exp_ready;

    tbl[0] = '{1, 8'h7F, 8'h01, 9'h080};
    tbl[1] = '{0, 8'h80, 8'hFF, 9'h17F};
    tbl[2] = '{2, 8'h7F, 8'h7F, 9'h0FE};
    tbl[3] = '{3, 8'h80, 8'h80, 9'h100};
    tbl[4] = '{1, 8'hFF, 8'h01, 9'h000};
    tbl[5] = '{3, 8'h05, 8'hFB, 9'h000};
    tbl[6] = '{2, 8'hC0, 8'hF0, 9'h1B0};

    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;

    // Table vectors with an ideal adder
    for (int i = 0; i < 7; i++) begin
      do_txn(tbl[i].id, tbl[i].a, tbl[i].b, 0, 4, tbl[i].s, 1'b0);
    end
    chk("err_cnt_clean", err_cnt, 0);

    // Transient fault on first RUN1: one retry
    do_txn(0, 8'h10, 8'h20, 1, 7, 9'h030, 1'b0);
    chk("err_cnt_after_retry", err_cnt, 0);

    // Persistent fault on every RUN2: all pairs fail
    do_txn(3, 8'h00, 8'h00, 2, 10, 9'h000, 1'b1);
    chk("err_cnt_after_fail", err_cnt, 1);

    // Backpressure
    @(negedge clk);
    req_valid = 4'b0100;
    req_a[16 +: 8] = 8'h33;
    req_b[16 +: 8] = 8'h44;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      #1 lat++;
    end
    chk("bp_valid_seen", rsp_valid, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid_hold", rsp_valid, 1);
      chk("bp_id_hold", rsp_id, 2);
      chk("bp_sum_hold", rsp_sum, 9'h077);
      chk("bp_err_hold", rsp_err, 0);
      chk("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_busy", busy, 0);

    // Reset during RUN2 drops the transaction
    req_valid = 4'b1000;
    req_a[24 +: 8] = 8'h01;
    req_b[24 +: 8] = 8'h02;
    @(negedge clk);
    #1;
    req_valid = '0;
    chk("run1_add_a", add_a, 8'h01);
    chk("run1_add_b", add_b, 8'h02);
    @(negedge clk);
    #1;
    chk("run2_add_a", add_a, 8'h02);
    chk("run2_add_b", add_b, 8'h01);
    rst_n = 1'b0;
    @(negedge clk);
    #1 chk_zero("midreset");
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 if (rsp_valid) n++;
    end
    chk("midreset_no_rsp", n, 0);

    // Round robin with all requesters active
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_a[8*i +: 8] = 8'(16*i + 1);
      req_b[8*i +: 8] = 8'(i);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    n = 0;
    last = 0;
    for (int c = 1; c <= 60 && n < 5; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) begin
        chk("rr_id", rsp_id, n % NR);
        chk("rr_sum", rsp_sum, sum_of(8'(16*(n % NR) + 1), 8'(n % NR)));
        if (n > 0) chk("rr_spacing", c - last, 5);
        last = c;
        n++;
      end
    end
    req_valid = '0;
    chk("rr_count", n, 5);

    // Randomized traffic against the transaction model
    do_reset();
    m_idle = 1;
    m_wait = 0;
    m_id = 0;
    m_ptr = 0;
    m_sum = '0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      req_a = $urandom;
      req_b = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      if (m_idle != 0) begin
        for (int k = 0; k < NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("rnd_ready", req_ready, exp_ready);
      chk("rnd_busy", busy, (m_idle == 0));
      chk("rnd_valid", rsp_valid, (m_idle == 0 && m_wait == 0));
      if (m_idle == 0 && m_wait == 0) begin
        chk("rnd_id", rsp_id, m_id);
        chk("rnd_sum", rsp_sum, m_sum);
        chk("rnd_err", rsp_err, 0);
      end
      if (m_idle != 0) begin
        if (g >= 0) begin
          m_idle = 0;
          m_wait = 3;
          m_id = g;
          m_sum = sum_of(req_a[8*g +: 8], req_b[8*g +: 8]);
          m_ptr = (g + 1) % NR;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (rsp_ready) begin
        m_idle = 1;
      end
    end
    chk("rnd_err_cnt", err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
